// File: rtl/heap_bank_array_pkg.sv
// Shared types and elaboration helpers for the banked heap storage.
// No logic of its own; imported by heap_bank and heap_bank_array.
package heap_bank_array_pkg;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Local word index width once the bank-select bits are stripped off.
  function automatic int laddr_w(input int addr_w, input int banks);
    return addr_w - $clog2(banks);
  endfunction

  function automatic bit rd_lat_legal(input int rd_lat);
    return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/heap_bank.sv
// One 1R1W bank with write-first bypass; read data RD_LAT cycles after address.
// No backpressure: a write and a read are accepted every cycle.
module heap_bank
  import heap_bank_array_pkg::*;
#(
  parameter int DATA_W  = 7,
  parameter int LADDR_W = 5,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               we,
  input  logic [LADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [LADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  // An out-of-range RD_LAT degrades to the single-register pipeline.
  localparam bit EXTRA_STAGE = rd_lat_legal(RD_LAT) && (RD_LAT == RD_LAT_MAX);

  logic [DATA_W-1:0] mem [2**LADDR_W];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      rd_q <= '0;
    end else if (we && (waddr == raddr)) begin
      rd_q <= wdata;
    end else begin
      rd_q <= mem[raddr];
    end
  end

  generate
    if (EXTRA_STAGE) begin : g_lat2
      logic [DATA_W-1:0] rd2_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd2_q <= '0;
        end else begin
          rd2_q <= rd_q;
        end
      end
      assign rdata = rd2_q;
    end else begin : g_lat1
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/heap_bank_array.sv
// BANKS parallel heap banks plus a shared init sweep that clears them after reset.
// No backpressure; o_ready stays low for 2^LADDR_W cycles while the sweep runs.
module heap_bank_array
  import heap_bank_array_pkg::*;
#(
  parameter int                BANKS    = 16,
  parameter int                DATA_W   = 7,
  parameter int                ADDR_W   = 9,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [BANKS-1:0]               i_wr_en,
  input  logic [BANKS-1:0][ADDR_W-1:0]   i_wr_addr,
  input  logic [BANKS-1:0][DATA_W-1:0]   i_wr_data,
  input  logic [BANKS-1:0][ADDR_W-1:0]   i_rd_addr,
  output logic [BANKS-1:0][DATA_W-1:0]   o_rd_data,
  output logic                           o_ready
);

  localparam int LADDR_W = laddr_w(ADDR_W, BANKS);

  state_e             state_q, state_d;
  logic [LADDR_W-1:0] cnt_q, cnt_d;
  logic               init;
  logic               run;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {LADDR_W{1'b1}}) begin
        state_d = S_RUN;
      end
    end
  end

  assign init    = (state_q == S_INIT);
  assign run     = (state_q == S_RUN);
  assign o_ready = run;

  // Bank-select bits were already consumed by the interconnect.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{i_wr_addr, i_rd_addr};

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic               we;
      logic [LADDR_W-1:0] waddr;
      logic [DATA_W-1:0]  wdata;

      // No writes land on a reset edge; the sweep owns the write port during init.
      assign we    = i_rst && (init || i_wr_en[b]);
      assign waddr = init ? cnt_q : i_wr_addr[b][LADDR_W-1:0];
      assign wdata = init ? INIT_VAL : i_wr_data[b];

      heap_bank #(
        .DATA_W  (DATA_W),
        .LADDR_W (LADDR_W),
        .RD_LAT  (RD_LAT)
      ) u_bank (
        .clk   (i_clk),
        .rst_n (i_rst),
        .run   (run),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (i_rd_addr[b][LADDR_W-1:0]),
        .rdata (o_rd_data[b])
      );
    end
  endgenerate

endmodule
